// File: rtl/slv_burst_monitor.sv
//==============================================================================
// Module   : slv_burst_monitor
// Brief    : AXI4 slave responder/checker for one crossbar slave port. INCR
//            bursts, per-beat WDATA/WLAST checking, generated read data and
//            sticky error reporting. Optional random stalls under the macro
//            SLV_BURST_MONITOR_STALL_EN.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module slv_burst_monitor #(
    parameter int          AXI_ADDR_W = 8,
    parameter int          AXI_ID_W   = 8,
    parameter int          AXI_DATA_W = 8,
    parameter int          OSTDG_W    = 3,
    parameter logic [3:0]  ERR_REGION = 4'hF,
    parameter int          TIMEOUT    = 100,
    parameter logic [31:0] KEY        = 32'hFFFFFFFF
) (
    input  logic                    aclk_i,
    input  logic                    srst_i,
    output logic                    error_o,
    output logic [3:0]              error_code_o,
    input  logic                    awvalid_i,
    output logic                    awready_o,
    input  logic [AXI_ADDR_W-1:0]   awaddr_i,
    input  logic [7:0]              awlen_i,
    input  logic [2:0]              awsize_i,
    input  logic [1:0]              awburst_i,
    input  logic [AXI_ID_W-1:0]     awid_i,
    input  logic [1:0]              awlock_i,
    input  logic [3:0]              awcache_i,
    input  logic [2:0]              awprot_i,
    input  logic [3:0]              awqos_i,
    input  logic [3:0]              awregion_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    input  logic                    wlast_i,
    input  logic [AXI_DATA_W-1:0]   wdata_i,
    input  logic [AXI_DATA_W/8-1:0] wstrb_i,
    output logic                    bvalid_o,
    input  logic                    bready_i,
    output logic [AXI_ID_W-1:0]     bid_o,
    output logic [1:0]              bresp_o,
    input  logic                    arvalid_i,
    output logic                    arready_o,
    input  logic [AXI_ADDR_W-1:0]   araddr_i,
    input  logic [7:0]              arlen_i,
    input  logic [2:0]              arsize_i,
    input  logic [1:0]              arburst_i,
    input  logic [AXI_ID_W-1:0]     arid_i,
    input  logic [1:0]              arlock_i,
    input  logic [3:0]              arcache_i,
    input  logic [2:0]              arprot_i,
    input  logic [3:0]              arqos_i,
    input  logic [3:0]              arregion_i,
    output logic                    rvalid_o,
    input  logic                    rready_i,
    output logic [AXI_ID_W-1:0]     rid_o,
    output logic [1:0]              rresp_o,
    output logic [AXI_DATA_W-1:0]   rdata_o,
    output logic                    rlast_o
);

    localparam int                NBYTES  = AXI_DATA_W / 8;
    localparam int                DEPTH   = 1 << OSTDG_W;
    localparam int                AX_W    = AXI_ID_W + AXI_ADDR_W + 8;
    localparam int                B_W     = AXI_ID_W + 2;
    localparam int                TO_W    = $clog2(TIMEOUT + 2);
    localparam logic [TO_W-1:0]   TO_LIM  = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0]   TO_ONE  = TO_W'(1);
    localparam logic [OSTDG_W:0]  PTR_ONE = {{OSTDG_W{1'b0}}, 1'b1};
    localparam logic [OSTDG_W:0]  PTR_MSB = {1'b1, {OSTDG_W{1'b0}}};

    typedef enum logic [0:0] {R_IDLE = 1'b0, R_BURST = 1'b1} r_state_e;

    function automatic logic [AXI_DATA_W-1:0] exp_data(input logic [AXI_ADDR_W-1:0] a,
                                                       input logic [7:0] k);
        logic [AXI_ADDR_W-1:0] s;
        s = a + AXI_ADDR_W'(int'(k) * NBYTES);
        for (int i = 0; i < AXI_DATA_W; i++) exp_data[i] = s[i % AXI_ADDR_W];
    endfunction

    function automatic logic [1:0] resp_of(input logic [AXI_ADDR_W-1:0] a);
        return (a[AXI_ADDR_W-1 -: 4] == ERR_REGION) ? 2'b10 : 2'b00;
    endfunction

    // Channel order: 0 AW, 1 W, 2 B, 3 AR, 4 R
    logic [4:0] w_stall_ok;
`ifdef SLV_BURST_MONITOR_STALL_EN
    localparam logic [63:0] KEY2 = {KEY, KEY};
    for (genvar g = 0; g < 5; g++) begin : g_lfsr
        logic [31:0] lfsr_q;
        always_ff @(posedge aclk_i) begin
            if (srst_i)        lfsr_q <= KEY2[63-7*g -: 32];
            else if (lfsr_q[0]) lfsr_q <= (lfsr_q >> 1) ^ 32'h80200003;
            else               lfsr_q <= lfsr_q >> 1;
        end
        assign w_stall_ok[g] = lfsr_q[0];
    end
`else
    assign w_stall_ok = '1;
`endif

    logic                  run_q, bheld_q, rheld_q, wbad_q;
    logic [7:0]            wcnt_q;
    logic [3:0]            err_q;
    logic [TO_W-1:0]       bto_q, rto_q;
    logic [AX_W-1:0]       aw_mem_q [DEPTH];
    logic [AX_W-1:0]       ar_mem_q [DEPTH];
    logic [B_W-1:0]        b_mem_q  [DEPTH];
    logic [OSTDG_W:0]      aw_wp_q, aw_rp_q, ar_wp_q, ar_rp_q, b_wp_q, b_rp_q;
    logic                  w_aw_empty, w_aw_full, w_ar_empty, w_ar_full, w_b_empty, w_b_full;
    logic                  w_aw_push, w_aw_pop, w_ar_push, w_ar_pop, w_b_push, w_b_pop;
    logic                  w_w_hs, w_wdata_bad, w_wlast_bad, w_burst_bad;
    logic [AXI_ID_W-1:0]   w_aw_id, w_ar_id;
    logic [AXI_ADDR_W-1:0] w_aw_addr, w_ar_addr;
    logic [7:0]            w_aw_len, w_ar_len;
    logic [AXI_DATA_W-1:0] w_wexp;
    r_state_e              r_state_q, r_state_d;
    logic [7:0]            rcnt_q, rcnt_d, rlen_q, rlen_d;
    logic [AXI_ID_W-1:0]   rid_q, rid_d;
    logic [AXI_ADDR_W-1:0] raddr_q, raddr_d;

    // Full when pointers differ only in the wrap bit
    assign w_aw_empty = (aw_wp_q == aw_rp_q);
    assign w_aw_full  = ((aw_wp_q ^ aw_rp_q) == PTR_MSB);
    assign w_ar_empty = (ar_wp_q == ar_rp_q);
    assign w_ar_full  = ((ar_wp_q ^ ar_rp_q) == PTR_MSB);
    assign w_b_empty  = (b_wp_q == b_rp_q);
    assign w_b_full   = ((b_wp_q ^ b_rp_q) == PTR_MSB);

    assign {w_aw_id, w_aw_addr, w_aw_len} = aw_mem_q[aw_rp_q[OSTDG_W-1:0]];
    assign {w_ar_id, w_ar_addr, w_ar_len} = ar_mem_q[ar_rp_q[OSTDG_W-1:0]];
    assign {bid_o, bresp_o}               = b_mem_q[b_rp_q[OSTDG_W-1:0]];

    assign awready_o = run_q & ~w_aw_full & w_stall_ok[0];
    assign wready_o  = run_q & ~w_aw_empty & ~w_b_full & w_stall_ok[1];
    assign arready_o = run_q & ~w_ar_full & w_stall_ok[3];
    assign bvalid_o  = ~w_b_empty & (w_stall_ok[2] | bheld_q);
    assign rvalid_o  = (r_state_q == R_BURST) & (w_stall_ok[4] | rheld_q);

    assign w_aw_push = awvalid_i & awready_o;
    assign w_ar_push = arvalid_i & arready_o;
    assign w_w_hs    = wvalid_i & wready_o;
    assign w_aw_pop  = w_w_hs & wlast_i;
    assign w_b_push  = w_aw_pop;
    assign w_b_pop   = bvalid_o & bready_i;

    assign w_wexp = exp_data(w_aw_addr, wcnt_q);
    always_comb begin
        w_wdata_bad = 1'b0;
        for (int b = 0; b < NBYTES; b++) begin
            if (wstrb_i[b] && (wdata_i[8*b +: 8] != w_wexp[8*b +: 8])) w_wdata_bad = 1'b1;
        end
    end
    assign w_wlast_bad = wlast_i ? (wcnt_q != w_aw_len) : (wcnt_q == w_aw_len);
    assign w_burst_bad = wbad_q | w_wdata_bad | w_wlast_bad;

    always_ff @(posedge aclk_i) begin
        if (w_aw_push) aw_mem_q[aw_wp_q[OSTDG_W-1:0]] <= {awid_i, awaddr_i, awlen_i};
        if (w_ar_push) ar_mem_q[ar_wp_q[OSTDG_W-1:0]] <= {arid_i, araddr_i, arlen_i};
        if (w_b_push)  b_mem_q[b_wp_q[OSTDG_W-1:0]]   <= {w_aw_id, w_burst_bad ? 2'b10 : resp_of(w_aw_addr)};
    end

    always_ff @(posedge aclk_i) begin
        if (srst_i) begin
            run_q   <= 1'b0;
            aw_wp_q <= '0;
            aw_rp_q <= '0;
            ar_wp_q <= '0;
            ar_rp_q <= '0;
            b_wp_q  <= '0;
            b_rp_q  <= '0;
            wcnt_q  <= '0;
            wbad_q  <= 1'b0;
            bheld_q <= 1'b0;
            rheld_q <= 1'b0;
            bto_q   <= '0;
            rto_q   <= '0;
            err_q   <= '0;
        end else begin
            run_q <= 1'b1;
            if (w_aw_push) aw_wp_q <= aw_wp_q + PTR_ONE;
            if (w_aw_pop)  aw_rp_q <= aw_rp_q + PTR_ONE;
            if (w_ar_push) ar_wp_q <= ar_wp_q + PTR_ONE;
            if (w_ar_pop)  ar_rp_q <= ar_rp_q + PTR_ONE;
            if (w_b_push)  b_wp_q  <= b_wp_q + PTR_ONE;
            if (w_b_pop)   b_rp_q  <= b_rp_q + PTR_ONE;
            if (w_w_hs) begin
                wcnt_q <= wlast_i ? 8'd0 : wcnt_q + 8'd1;
                wbad_q <= wlast_i ? 1'b0 : w_burst_bad;
            end
            bheld_q <= bvalid_o & ~bready_i;
            rheld_q <= rvalid_o & ~rready_i;
            if (bvalid_o && !bready_i) begin
                if (bto_q != TO_LIM) bto_q <= bto_q + TO_ONE;
            end else begin
                bto_q <= '0;
            end
            if (rvalid_o && !rready_i) begin
                if (rto_q != TO_LIM) rto_q <= rto_q + TO_ONE;
            end else begin
                rto_q <= '0;
            end
            err_q[0] <= err_q[0] | (w_w_hs & w_wdata_bad);
            err_q[1] <= err_q[1] | (w_w_hs & w_wlast_bad);
            err_q[2] <= err_q[2] | (bto_q == TO_LIM);
            err_q[3] <= err_q[3] | (rto_q == TO_LIM);
        end
    end

    assign error_code_o = err_q;
    assign error_o      = |err_q;

    always_comb begin
        r_state_d = r_state_q;
        rcnt_d    = rcnt_q;
        rlen_d    = rlen_q;
        rid_d     = rid_q;
        raddr_d   = raddr_q;
        w_ar_pop  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (!w_ar_empty) begin
                    w_ar_pop  = 1'b1;
                    rid_d     = w_ar_id;
                    raddr_d   = w_ar_addr;
                    rlen_d    = w_ar_len;
                    rcnt_d    = 8'd0;
                    r_state_d = R_BURST;
                end
            end
            R_BURST: begin
                if (rvalid_o && rready_i) begin
                    rcnt_d = rcnt_q + 8'd1;
                    if (rlast_o) r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk_i) begin
        if (srst_i) begin
            r_state_q <= R_IDLE;
            rcnt_q    <= '0;
            rlen_q    <= '0;
            rid_q     <= '0;
            raddr_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            rcnt_q    <= rcnt_d;
            rlen_q    <= rlen_d;
            rid_q     <= rid_d;
            raddr_q   <= raddr_d;
        end
    end

    assign rid_o   = rid_q;
    assign rlast_o = (rcnt_q == rlen_q);
    assign rdata_o = exp_data(raddr_q, rcnt_q);
    assign rresp_o = resp_of(raddr_q);

    logic w_unused;
    assign w_unused = ^{awsize_i, awburst_i, awlock_i, awcache_i, awprot_i, awqos_i, awregion_i,
                        arsize_i, arburst_i, arlock_i, arcache_i, arprot_i, arqos_i, arregion_i, KEY};

endmodule

`default_nettype wire
